// File: rtl/score_history_reader_pkg.sv
// Shared constants, reader state encoding and BCD helper for the score path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package score_history_reader_pkg;

  localparam int ADDR_W       = 8;
  localparam int SCORE_W      = 32;
  localparam int DIGITS       = 10;
  localparam int READ_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CONV = 2'd2,
    ST_SHOW = 2'd3
  } reader_state_t;

  // Double-dabble correction: a nibble of 5 or more gets +3 before the shift.
  function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/score_history_reader_if.sv
// Bundle of FSM, score-RAM and display-side signals of the history reader.
// Latency: n/a (wiring only).
// Backpressure: none; next/prev are pulses, consumers gate on digitsValid.
interface score_history_reader_if #(
  parameter int ADDR_W  = score_history_reader_pkg::ADDR_W,
  parameter int SCORE_W = score_history_reader_pkg::SCORE_W,
  parameter int DIGITS  = score_history_reader_pkg::DIGITS
);

  logic                  ld_score;
  logic                  next;
  logic                  prev;
  logic [ADDR_W-1:0]     latestAddress;
  logic [SCORE_W-1:0]    readData;
  logic [ADDR_W-1:0]     readAddress;
  logic [4*DIGITS-1:0]   bcd;
  logic [ADDR_W-1:0]     entryIndex;
  logic                  digitsValid;
  logic                  busy;

  // Reader side.
  modport master (
    input  ld_score, next, prev, latestAddress, readData,
    output readAddress, bcd, entryIndex, digitsValid, busy
  );

  // FSM / RAM / display side.
  modport slave (
    output ld_score, next, prev, latestAddress, readData,
    input  readAddress, bcd, entryIndex, digitsValid, busy
  );

endinterface

// File: rtl/score_history_reader_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/done handshake.
// Latency: done pulses SCORE_W cycles after start; bcd updates with done.
// Backpressure: none; a new start aborts and restarts any conversion in flight.
module bin2bcd_seq #(
  parameter int SCORE_W = score_history_reader_pkg::SCORE_W,
  parameter int DIGITS  = score_history_reader_pkg::DIGITS
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic                start,
  input  logic [SCORE_W-1:0]  bin,
  output logic [4*DIGITS-1:0] bcd,
  output logic                done
);
  import score_history_reader_pkg::*;

  localparam int CNT_W = $clog2(SCORE_W + 1);

  logic                running;
  logic [CNT_W-1:0]    cnt;
  logic [SCORE_W-1:0]  shreg;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] acc_nx;
  logic [SCORE_W-1:0]  shreg_nx;

  // One dabble step: correct every nibble, then shift the pair left by one.
  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj[4*d +: 4] = dabble_adjust(acc[4*d +: 4]);
    end
    {acc_nx, shreg_nx} = {adj, shreg} << 1;
  end

  // Load on start, shift while running, publish result on the last shift.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      running <= 1'b0;
      cnt     <= '0;
      shreg   <= '0;
      acc     <= '0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg   <= bin;
        acc     <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        acc   <= acc_nx;
        shreg <= shreg_nx;
        cnt   <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(SCORE_W - 1)) begin
          running <= 1'b0;
          bcd     <= acc_nx;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/score_history_reader.sv
// Reads stored scores back from the score RAM and converts them to BCD for display.
// Latency: digitsValid rises READ_LATENCY+SCORE_W+2 cycles after ld_score rise or a step.
// Backpressure: none; next/prev outside the result-holding state are dropped.
module score_history_reader #(
  parameter int ADDR_W       = score_history_reader_pkg::ADDR_W,
  parameter int SCORE_W      = score_history_reader_pkg::SCORE_W,
  parameter int DIGITS       = score_history_reader_pkg::DIGITS,
  parameter int READ_LATENCY = score_history_reader_pkg::READ_LATENCY
) (
  input  logic                  Clock,
  input  logic                  reset,
  score_history_reader_if.master bus
);
  import score_history_reader_pkg::*;

  // +2 keeps the counter at least one bit wide even for a zero-latency RAM.
  localparam int LAT_W = $clog2(READ_LATENCY + 2);

  reader_state_t       state, state_nx;
  logic                ld_d;
  logic [ADDR_W-1:0]   cursor, cursor_nx;
  logic [ADDR_W-1:0]   read_addr, read_addr_nx;
  logic [LAT_W-1:0]    lat_cnt, lat_cnt_nx;
  logic [4*DIGITS-1:0] bcd_r, bcd_nx;
  logic [ADDR_W-1:0]   entry_r, entry_nx;
  logic                valid_r, valid_nx;
  logic                busy_r, busy_nx;

  logic                trigger;
  logic                step_older;
  logic                step_newer;
  logic                conv_start;
  logic [4*DIGITS-1:0] conv_bcd;
  logic                conv_done;

  bin2bcd_seq #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_bin2bcd (
    .Clock (Clock),
    .reset (reset),
    .start (conv_start),
    .bin   (bus.readData),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  assign trigger    = bus.ld_score & ~ld_d;
  assign step_older = bus.next & ~bus.prev;
  assign step_newer = bus.prev & ~bus.next;

  // Next-state and register updates; ld_score low overrides, then a fresh rise.
  always_comb begin
    state_nx     = state;
    cursor_nx    = cursor;
    read_addr_nx = read_addr;
    lat_cnt_nx   = lat_cnt;
    bcd_nx       = bcd_r;
    entry_nx     = entry_r;
    valid_nx     = valid_r;
    busy_nx      = busy_r;
    conv_start   = 1'b0;

    if (!bus.ld_score) begin
      state_nx = ST_IDLE;
      valid_nx = 1'b0;
      busy_nx  = 1'b0;
    end else if (trigger) begin
      cursor_nx    = bus.latestAddress;
      read_addr_nx = bus.latestAddress;
      lat_cnt_nx   = '0;
      state_nx     = ST_READ;
      valid_nx     = 1'b0;
      busy_nx      = 1'b1;
    end else begin
      case (state)
        ST_READ: begin
          if (lat_cnt == LAT_W'(READ_LATENCY)) begin
            conv_start = 1'b1;
            state_nx   = ST_CONV;
          end else begin
            lat_cnt_nx = lat_cnt + LAT_W'(1);
          end
        end
        ST_CONV: begin
          if (conv_done) begin
            bcd_nx   = conv_bcd;
            entry_nx = cursor;
            valid_nx = 1'b1;
            busy_nx  = 1'b0;
            state_nx = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (step_older || step_newer) begin
            cursor_nx    = step_older ? cursor - ADDR_W'(1) : cursor + ADDR_W'(1);
            read_addr_nx = cursor_nx;
            lat_cnt_nx   = '0;
            state_nx     = ST_READ;
            valid_nx     = 1'b0;
            busy_nx      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ld_d      <= 1'b0;
      cursor    <= '0;
      read_addr <= '0;
      lat_cnt   <= '0;
      bcd_r     <= '0;
      entry_r   <= '0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state     <= state_nx;
      ld_d      <= bus.ld_score;
      cursor    <= cursor_nx;
      read_addr <= read_addr_nx;
      lat_cnt   <= lat_cnt_nx;
      bcd_r     <= bcd_nx;
      entry_r   <= entry_nx;
      valid_r   <= valid_nx;
      busy_r    <= busy_nx;
    end
  end

  assign bus.readAddress = read_addr;
  assign bus.bcd         = bcd_r;
  assign bus.entryIndex  = entry_r;
  assign bus.digitsValid = valid_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_score_history_reader.sv
// Bench for score_history_reader: RAM model, transaction-level reference, per-cycle compare.
// Latency: reference expects results READ_LATENCY+SCORE_W+2 cycles after each read issue.
// Backpressure: n/a.
module tb_score_history_reader;

  localparam int AW        = score_history_reader_pkg::ADDR_W;
  localparam int SW        = score_history_reader_pkg::SCORE_W;
  localparam int ND        = score_history_reader_pkg::DIGITS;
  localparam int LAT_TOTAL = score_history_reader_pkg::READ_LATENCY + SW + 2;

  logic Clock;
  logic reset;

  score_history_reader_if bus ();

  score_history_reader dut (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Score RAM model: two registered stages from address to q.
  logic [SW-1:0] mem [256];
  logic [SW-1:0] q1, q2;
  always @(posedge Clock) begin
    q1 <= mem[bus.readAddress];
    q2 <= q1;
  end
  assign bus.readData = q2;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*ND-1:0] to_bcd(input logic [SW-1:0] v);
    longint unsigned x;
    logic [4*ND-1:0] r;
    x = 64'(v);
    r = '0;
    for (int d = 0; d < ND; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference model: what the display must show, from the behavioural rules.
  logic            cmp_en = 1'b0;
  logic            m_ld_d;
  logic            m_valid, m_busy, m_pending;
  logic [AW-1:0]   m_cursor, m_raddr, m_entry;
  logic [4*ND-1:0] m_bcd;
  int              m_timer;

  task automatic m_issue(input logic [AW-1:0] a);
    m_cursor  = a;
    m_raddr   = a;
    m_valid   = 1'b0;
    m_busy    = 1'b1;
    m_pending = 1'b1;
    m_timer   = LAT_TOTAL;
  endtask

  always @(posedge Clock) begin
    if (!reset) begin
      m_ld_d = 1'b0; m_valid = 1'b0; m_busy = 1'b0; m_pending = 1'b0;
      m_cursor = '0; m_raddr = '0; m_entry = '0; m_bcd = '0; m_timer = 0;
      cmp_en = 1'b1;
    end else begin
      if (!bus.ld_score) begin
        m_valid = 1'b0; m_busy = 1'b0; m_pending = 1'b0;
      end else if (!m_ld_d) begin
        m_issue(bus.latestAddress);
      end else if (m_pending) begin
        m_timer--;
        if (m_timer == 0) begin
          m_pending = 1'b0;
          m_valid   = 1'b1;
          m_busy    = 1'b0;
          m_entry   = m_cursor;
          m_bcd     = to_bcd(mem[m_cursor]);
        end
      end else if (m_valid && (bus.next != bus.prev)) begin
        m_issue(bus.next ? AW'(m_cursor - AW'(1)) : AW'(m_cursor + AW'(1)));
      end
      m_ld_d = bus.ld_score;
    end
  end

  // Every-cycle comparison of all outputs against the reference.
  always @(negedge Clock) begin
    if (cmp_en) begin
      check("cyc_readAddress", 64'(bus.readAddress), 64'(m_raddr));
      check("cyc_bcd",         64'(bus.bcd),         64'(m_bcd));
      check("cyc_entryIndex",  64'(bus.entryIndex),  64'(m_entry));
      check("cyc_digitsValid", 64'(bus.digitsValid), 64'(m_valid));
      check("cyc_busy",        64'(bus.busy),        64'(m_busy));
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.digitsValid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      failures++;
      checks++;
      $display("FAIL wait_valid: digitsValid not seen within %0d cycles", n);
    end
  endtask

  task automatic retrigger(input logic [AW-1:0] a, input logic [SW-1:0] v);
    bus.ld_score = 1'b0;
    tick();
    tick();
    mem[a] = v;
    bus.latestAddress = a;
    bus.ld_score = 1'b1;
    tick();
  endtask

  task automatic pulse_next();
    bus.next = 1'b1; tick(); bus.next = 1'b0;
  endtask

  task automatic pulse_prev();
    bus.prev = 1'b1; tick(); bus.prev = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b0;
    bus.ld_score = 1'b0; bus.next = 1'b0; bus.prev = 1'b0;
    bus.latestAddress = '0;
    tick(); tick(); tick();
    check("rst_readAddress", 64'(bus.readAddress), 64'd0);
    check("rst_bcd",         64'(bus.bcd),         64'd0);
    check("rst_entryIndex",  64'(bus.entryIndex),  64'd0);
    check("rst_digitsValid", 64'(bus.digitsValid), 64'd0);
    check("rst_busy",        64'(bus.busy),        64'd0);
    reset = 1'b1;
    tick();

    // Newest entry first, with exact trigger-to-valid latency.
    mem[5] = 32'd1234;
    bus.latestAddress = 8'd5;
    bus.ld_score = 1'b1;
    tick();
    check("s1_readAddress", 64'(bus.readAddress), 64'd5);
    check("s1_busy",        64'(bus.busy),        64'd1);
    wait_valid(n);
    check("s1_latency",     64'(n),               64'd36);
    check("s1_bcd",         64'(bus.bcd),         64'h0000001234);
    check("s1_entry",       64'(bus.entryIndex),  64'd5);

    // Cursor wrap both ways.
    mem[255] = 32'd99;
    retrigger(8'd0, 32'd7);
    wait_valid(n);
    check("s2_entry0", 64'(bus.entryIndex), 64'd0);
    check("s2_bcd0",   64'(bus.bcd),        64'h7);
    pulse_next();
    wait_valid(n);
    check("s2_entry255", 64'(bus.entryIndex), 64'd255);
    check("s2_bcd255",   64'(bus.bcd),        64'h99);
    pulse_prev();
    wait_valid(n);
    check("s2_entry0b", 64'(bus.entryIndex), 64'd0);
    check("s2_bcd0b",   64'(bus.bcd),        64'h7);

    // Extremes of the score range.
    retrigger(8'd10, 32'hFFFF_FFFF);
    wait_valid(n);
    check("s3_max_bcd", 64'(bus.bcd), 64'h4294967295);
    retrigger(8'd11, 32'd0);
    wait_valid(n);
    check("s3_zero_bcd",   64'(bus.bcd),         64'h0);
    check("s3_zero_valid", 64'(bus.digitsValid), 64'd1);

    // next during conversion is dropped; next+prev together in SHOW is dropped.
    retrigger(8'd5, 32'd1234);
    repeat (13) tick();
    pulse_next();
    wait_valid(n);
    check("s4_entry", 64'(bus.entryIndex), 64'd5);
    bus.next = 1'b1; bus.prev = 1'b1;
    tick();
    bus.next = 1'b0; bus.prev = 1'b0;
    repeat (3) tick();
    check("s4_both_valid", 64'(bus.digitsValid), 64'd1);
    check("s4_both_busy",  64'(bus.busy),        64'd0);
    check("s4_both_addr",  64'(bus.readAddress), 64'd5);

    // Abort mid-conversion, then restart from a new latest address.
    retrigger(8'd20, 32'd555);
    repeat (13) tick();
    bus.ld_score = 1'b0;
    tick();
    check("s5_busy",  64'(bus.busy),        64'd0);
    check("s5_valid", 64'(bus.digitsValid), 64'd0);
    seen = 0;
    repeat (50) begin
      tick();
      if (bus.digitsValid === 1'b1) seen++;
    end
    check("s5_no_late_valid", 64'(seen), 64'd0);
    mem[9] = 32'd4321;
    bus.latestAddress = 8'd9;
    bus.ld_score = 1'b1;
    tick();
    check("s5_addr9", 64'(bus.readAddress), 64'd9);
    wait_valid(n);
    check("s5_bcd9", 64'(bus.bcd), 64'h4321);

    // Reset in the middle of a read.
    retrigger(8'd30, 32'd77);
    tick();
    reset = 1'b0;
    bus.ld_score = 1'b0;
    tick();
    check("s6_readAddress", 64'(bus.readAddress), 64'd0);
    check("s6_bcd",         64'(bus.bcd),         64'd0);
    check("s6_entry",       64'(bus.entryIndex),  64'd0);
    check("s6_valid",       64'(bus.digitsValid), 64'd0);
    check("s6_busy",        64'(bus.busy),        64'd0);
    reset = 1'b1;
    tick();
    pulse_next();
    repeat (5) tick();
    check("s6_no_read_busy", 64'(bus.busy),        64'd0);
    check("s6_no_read_addr", 64'(bus.readAddress), 64'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 7))
        0:       mem[i] = '0;
        1:       mem[i] = '1;
        default: mem[i] = $urandom;
      endcase
    end
    tick();
    bus.ld_score = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (bus.ld_score && $urandom_range(0, 299) == 0) bus.ld_score = 1'b0;
      else if (!bus.ld_score && $urandom_range(0, 4) == 0) bus.ld_score = 1'b1;
      if ($urandom_range(0, 19) == 0) bus.latestAddress = AW'($urandom);
      bus.next = ($urandom_range(0, 39) == 0);
      bus.prev = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 1999) != 0);
      tick();
    end
    reset = 1'b1;
    bus.next = 1'b0; bus.prev = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
